hamming_sequenciador: RTL and testbench
=======================================

Name: hamming_sequenciador

Overview:
- Sequential controller for the Hamming(15,11) encode -> error-inject -> correct datapath (calcula_hamming, injetor, corrige_hamming).
- Accepts 16-bit test words over a valid/ready handshake and applies them to the datapath one at a time.
- Waits a programmable settle time, samples the corrected data, compares it with the original and returns a result over a second handshake.
- Keeps saturating pass/fail statistics; sits between the test-vector source (file loader or CPU) and the datapath.

Parameters:
LATENCIA, 1, cycles between driving dp_* and sampling dp_saida; legal range 1..15.
CONT_W, 16, width of the statistics counters.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  test word present.
in_ready  output  1  controller can accept a word.
in_dado  input  16  test word: [15:5] data, [4:1] bit position n, [0] inject flag.
dp_entrada  output  11  to calcula_hamming.entrada.
dp_n  output  4  to injetor.n.
dp_erro  output  1  to injetor.erro.
dp_saida  input  11  from corrige_hamming.saida.
out_valid  output  1  result available.
out_ready  input  1  consumer takes result.
res_dado  output  11  original data of the vector.
res_saida  output  11  sampled corrected data.
res_ok  output  1  1 when res_saida == res_dado.
res_n_invalido  output  1  vector requested injection at n=15.
limpa  input  1  synchronous clear of the statistics counters.
cnt_total  output  CONT_W  vectors completed.
cnt_falha  output  CONT_W  vectors with res_ok=0.

Behaviour:
- Reset (async, rst_n=0):
  - State OCIOSO; in_ready=1; out_valid=0.
  - dp_entrada=0, dp_n=0, dp_erro=0.
  - All res_* = 0; both counters = 0.
  - Any in-flight vector is discarded; no count update for it.
- States:
  - OCIOSO: in_ready=1. On the edge where in_valid&&in_ready:
    - Register dp_entrada=in_dado[15:5] and dp_n=in_dado[4:1].
    - Register dp_erro=in_dado[0], except n=15 with in_dado[0]=1 drives dp_erro=0 and latches an invalid-n flag.
    - Clear the wait counter; go to ESPERA. in_ready drops the cycle after acceptance.
  - ESPERA: wait counter increments each cycle. On the edge where it reaches LATENCIA:
    - Sample dp_saida into res_saida; copy dp_entrada into res_dado.
    - res_ok = (dp_saida == dp_entrada); res_n_invalido = latched flag.
    - Update counters; go to RESULTADO.
    - out_valid rises exactly LATENCIA cycles after the accept edge.
  - RESULTADO: out_valid=1; res_* held stable. On the edge where out_ready=1, go to OCIOSO.
    - out_valid falls and in_ready rises together; no back-to-back overlap.
- dp_* outputs:
  - Hold their value until the next acceptance; never glitch in ESPERA or RESULTADO.
  - Signals that are not present in a given state hold their last value.
- Counters:
  - cnt_total +1 per capture; cnt_falha +1 per capture with res_ok=0.
  - Both saturate at 2^CONT_W-1.
  - limpa=1 forces both to 0 on the next edge and has priority over a simultaneous capture increment.
  - limpa does not affect the state machine.
- in_valid while in_ready=0 is ignored; the source must hold the word until the handshake completes.
- out_ready while out_valid=0 is ignored.
- Single-bit errors are always correctable, so res_ok=0 indicates a datapath fault.

Optional Feature:
HAMMING_AUTOERRO_EN:
- Defined:
  - in_dado[4:0] are ignored. dp_erro is forced to 1 and dp_n comes from an internal 4-bit position counter.
  - The counter resets to 0, advances by 1 on each acceptance and wraps 14->0, so 15 is never used.
  - res_n_invalido is always 0.
- Undefined: n and the inject flag come from the vector, as described above.

Test Plan:
1. Reset, then in_dado=16'b10101010101_0011_1, LATENCIA=1, out_ready=1 -> dp_n=3, dp_erro=1; out_valid 1 cycle after accept; res_dado=res_saida=11'h555; res_ok=1; cnt_total=1; cnt_falha=0.
2. Five vectors: data 0x000, 0x7FF, 0x123, 0x555, 0x2AA with n=0, 14, 7, 3, 10, inject flag 1 -> all res_ok=1; cnt_total=5; cnt_falha=0.
3. Bench-forced dp_saida=11'h001 while dp_entrada=11'h000 -> res_ok=0; cnt_falha increments to 1.
4. in_dado=11'h0F0 with n=15 and inject flag 1 -> dp_erro=0; res_n_invalido=1; res_ok=1.
5. LATENCIA=4, out_ready held 0 for 3 cycles -> out_valid at accept+4 with res_* stable; in_ready=0 until the out_ready edge; second in_valid ignored until then.
6. rst_n pulsed low in ESPERA -> all outputs return to reset values immediately and counters are 0. limpa asserted in the capture cycle -> counters read 0 afterwards.
7. With HAMMING_AUTOERRO_EN defined, 16 vectors -> dp_n sequence 0..14, 0; dp_erro=1 throughout.

Source files
------------

// File: rtl/hamming_sequenciador.sv
// Purpose: sequences 16-bit test words through the Hamming(15,11) encode/inject/correct datapath, checks the result and keeps pass/fail counts.
// Latency: dp_* registered on the accept edge; result (out_valid) rises LATENCIA cycles after the accept edge.
// Backpressure: one vector in flight; in_ready stays low until the consumer takes the result (out_valid && out_ready).
// Optional build: define HAMMING_AUTOERRO_EN to always inject, with positions from an internal 0..14 counter.
module hamming_sequenciador #(
    parameter int LATENCIA = 1,   // settle cycles, legal 1..15
    parameter int CONT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_dado,
    output logic [10:0]       dp_entrada,
    output logic [3:0]        dp_n,
    output logic              dp_erro,
    input  logic [10:0]       dp_saida,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [10:0]       res_dado,
    output logic [10:0]       res_saida,
    output logic              res_ok,
    output logic              res_n_invalido,
    input  logic              limpa,
    output logic [CONT_W-1:0] cnt_total,
    output logic [CONT_W-1:0] cnt_falha
);

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        ESPERA    = 2'd1,
        RESULTADO = 2'd2
    } estado_t;

    localparam logic [3:0]        LAT_FIM = 4'(LATENCIA);
    localparam logic [CONT_W-1:0] CNT_UM  = {{(CONT_W-1){1'b0}}, 1'b1};
    localparam logic [CONT_W-1:0] CNT_MAX = '1;

    estado_t    estado;
    logic [3:0] espera_cnt;
    logic       n_inv_lat;

    logic       aceita;
    logic       captura;
    logic       captura_ok;
    logic [3:0] n_sel;
    logic       erro_sel;
    logic       n_inv_sel;

    // in_ready is only high in OCIOSO, so a handshake always starts a new vector
    assign aceita     = in_valid && in_ready;
    // the k-th ESPERA edge sees espera_cnt == k-1; capture on the LATENCIA-th one
    assign captura    = (estado == ESPERA) && ((espera_cnt + 4'd1) == LAT_FIM);
    assign captura_ok = (dp_saida == dp_entrada);

`ifdef HAMMING_AUTOERRO_EN
    logic [3:0] pos_cnt;
    logic       unused_autoerro;

    // the vector's position/flag field is not used when positions are generated internally
    assign unused_autoerro = ^in_dado[4:0];

    // choose injection position from the internal counter, always inject
    always_comb begin
        n_sel     = pos_cnt;
        erro_sel  = 1'b1;
        n_inv_sel = 1'b0;
    end

    // position counter advances per accepted vector and skips 15 (no such codeword bit)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_cnt <= 4'd0;
        end else if (aceita) begin
            pos_cnt <= (pos_cnt == 4'd14) ? 4'd0 : pos_cnt + 4'd1;
        end
    end
`else
    // position and inject flag come from the vector; n=15 has no codeword bit, so suppress injection and flag it
    always_comb begin
        n_sel     = in_dado[4:1];
        erro_sel  = in_dado[0] && (in_dado[4:1] != 4'd15);
        n_inv_sel = in_dado[0] && (in_dado[4:1] == 4'd15);
    end
`endif

    // control FSM: registers datapath drive on accept, samples result after settle, holds it until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado         <= OCIOSO;
            in_ready       <= 1'b1;
            out_valid      <= 1'b0;
            dp_entrada     <= 11'd0;
            dp_n           <= 4'd0;
            dp_erro        <= 1'b0;
            res_dado       <= 11'd0;
            res_saida      <= 11'd0;
            res_ok         <= 1'b0;
            res_n_invalido <= 1'b0;
            espera_cnt     <= 4'd0;
            n_inv_lat      <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (aceita) begin
                        dp_entrada <= in_dado[15:5];
                        dp_n       <= n_sel;
                        dp_erro    <= erro_sel;
                        n_inv_lat  <= n_inv_sel;
                        espera_cnt <= 4'd0;
                        in_ready   <= 1'b0;
                        estado     <= ESPERA;
                    end
                end
                ESPERA: begin
                    if (captura) begin
                        res_saida      <= dp_saida;
                        res_dado       <= dp_entrada;
                        res_ok         <= captura_ok;
                        res_n_invalido <= n_inv_lat;
                        out_valid      <= 1'b1;
                        estado         <= RESULTADO;
                    end else begin
                        espera_cnt <= espera_cnt + 4'd1;
                    end
                end
                RESULTADO: begin
                    // out_valid falls and in_ready rises on the same edge: no overlap between vectors
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        estado    <= OCIOSO;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    estado    <= OCIOSO;
                end
            endcase
        end
    end

    // saturating statistics; limpa wins over a same-cycle capture and leaves the FSM alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_total <= '0;
            cnt_falha <= '0;
        end else if (limpa) begin
            cnt_total <= '0;
            cnt_falha <= '0;
        end else if (captura) begin
            if (cnt_total != CNT_MAX) begin
                cnt_total <= cnt_total + CNT_UM;
            end
            if (!captura_ok && (cnt_falha != CNT_MAX)) begin
                cnt_falha <= cnt_falha + CNT_UM;
            end
        end
    end

endmodule

// File: tb/tb_hamming_sequenciador.sv
module tb_hamming_sequenciador;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [1:0]        in_valid, in_ready, out_valid, out_ready, limpa;
    logic [1:0]        dp_erro, res_ok, res_n_invalido, force_en;
    logic [1:0][15:0]  in_dado;
    logic [1:0][10:0]  dp_entrada, dp_saida, res_dado, res_saida;
    logic [1:0][3:0]   dp_n;
    logic [1:0][15:0]  cnt_total, cnt_falha;
    logic [10:0]       force_val;

    // ideal datapath stub (single-bit errors always corrected), optionally overridden to emulate a fault
    assign dp_saida[0] = force_en[0] ? force_val : dp_entrada[0];
    assign dp_saida[1] = force_en[1] ? force_val : dp_entrada[1];

    hamming_sequenciador #(.LATENCIA(1), .CONT_W(16)) u_l1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_dado(in_dado[0]),
        .dp_entrada(dp_entrada[0]), .dp_n(dp_n[0]), .dp_erro(dp_erro[0]), .dp_saida(dp_saida[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .res_dado(res_dado[0]), .res_saida(res_saida[0]), .res_ok(res_ok[0]),
        .res_n_invalido(res_n_invalido[0]), .limpa(limpa[0]),
        .cnt_total(cnt_total[0]), .cnt_falha(cnt_falha[0])
    );

    hamming_sequenciador #(.LATENCIA(4), .CONT_W(16)) u_l4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_dado(in_dado[1]),
        .dp_entrada(dp_entrada[1]), .dp_n(dp_n[1]), .dp_erro(dp_erro[1]), .dp_saida(dp_saida[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .res_dado(res_dado[1]), .res_saida(res_saida[1]), .res_ok(res_ok[1]),
        .res_n_invalido(res_n_invalido[1]), .limpa(limpa[1]),
        .cnt_total(cnt_total[1]), .cnt_falha(cnt_falha[1])
    );

    typedef struct packed {
        logic [10:0] dado;
        logic [10:0] saida;
        logic        ok;
        logic        ninv;
    } exp_t;

    typedef struct {
        int          d;      // 0: LATENCIA=1 instance, 1: LATENCIA=4 instance
        logic [15:0] dado;
        bit          fe;     // force dp_saida
        logic [10:0] fv;
        int          hold;   // cycles out_ready held low after out_valid
        bit          lim;    // assert limpa through the capture
    } vec_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   exp_total[2];
    int   exp_falha[2];
    logic [3:0] pos[2];

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s[dut%0d]: got %0h, want %0h", nm, d, act, req);
        end
    endtask

    task automatic chk_reset(input int d);
        chk("rst_in_ready", d, in_ready[d], 1);
        chk("rst_out_valid", d, out_valid[d], 0);
        chk("rst_dp_entrada", d, dp_entrada[d], 0);
        chk("rst_dp_n", d, dp_n[d], 0);
        chk("rst_dp_erro", d, dp_erro[d], 0);
        chk("rst_res_dado", d, res_dado[d], 0);
        chk("rst_res_saida", d, res_saida[d], 0);
        chk("rst_res_ok", d, res_ok[d], 0);
        chk("rst_res_n_inv", d, res_n_invalido[d], 0);
        chk("rst_cnt_total", d, cnt_total[d], 0);
        chk("rst_cnt_falha", d, cnt_falha[d], 0);
    endtask

    task automatic reset_model();
        for (int i = 0; i < 2; i++) begin
            exp_total[i] = 0;
            exp_falha[i] = 0;
            pos[i] = 4'd0;
        end
        sb.delete();
    endtask

    // drive one vector through instance d, scoreboard its result, check timing and counters
    task automatic run_vec(input int d, input logic [15:0] dado, input bit fe,
                           input logic [10:0] fv, input int hold, input bit lim);
        exp_t e;
        exp_t got;
        logic [3:0] en;
        logic ee;
        logic [10:0] dat;
        int k;
        dat = dado[15:5];
        force_en[d] = fe;
        force_val = fv;
        out_ready[d] = (hold == 0);
        k = 0;
        while (!in_ready[d] && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("in_ready_wait", d, in_ready[d], 1);
        in_valid[d] = 1'b1;
        in_dado[d] = dado;
`ifdef HAMMING_AUTOERRO_EN
        en = pos[d];
        ee = 1'b1;
        e.ninv = 1'b0;
        pos[d] = (pos[d] == 4'd14) ? 4'd0 : pos[d] + 4'd1;
`else
        en = dado[4:1];
        ee = dado[0] && (dado[4:1] != 4'd15);
        e.ninv = dado[0] && (dado[4:1] == 4'd15);
`endif
        e.dado = dat;
        e.saida = fe ? fv : dat;
        e.ok = (e.saida == dat);
        sb.push_back(e);
        @(negedge clk);
        in_valid[d] = 1'b0;
        chk("dp_entrada", d, dp_entrada[d], dat);
        chk("dp_n", d, dp_n[d], en);
        chk("dp_erro", d, dp_erro[d], ee);
        chk("in_ready_busy", d, in_ready[d], 0);
        if (lim) limpa[d] = 1'b1;
        k = 0;
        while (!out_valid[d] && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("latency", d, k, lat_of(d));
        if (lim) begin
            limpa[d] = 1'b0;
            exp_total[d] = 0;
            exp_falha[d] = 0;
        end else begin
            exp_total[d]++;
            if (!e.ok) exp_falha[d]++;
        end
        got = sb.pop_front();
        chk("res_dado", d, res_dado[d], got.dado);
        chk("res_saida", d, res_saida[d], got.saida);
        chk("res_ok", d, res_ok[d], got.ok);
        chk("res_n_inv", d, res_n_invalido[d], got.ninv);
        chk("cnt_total", d, cnt_total[d], exp_total[d]);
        chk("cnt_falha", d, cnt_falha[d], exp_falha[d]);
        chk("dp_hold", d, dp_entrada[d], dat);
        if (hold > 0) begin
            // a competing word offered while the result waits must be ignored
            in_valid[d] = 1'b1;
            in_dado[d] = ~dado;
            repeat (hold) @(negedge clk);
            chk("hold_out_valid", d, out_valid[d], 1);
            chk("hold_in_ready", d, in_ready[d], 0);
            chk("hold_res_dado", d, res_dado[d], got.dado);
            chk("hold_res_saida", d, res_saida[d], got.saida);
            chk("hold_dp_entrada", d, dp_entrada[d], dat);
            out_ready[d] = 1'b1;
            in_valid[d] = 1'b0;
        end
        @(negedge clk);
        chk("done_out_valid", d, out_valid[d], 0);
        chk("done_in_ready", d, in_ready[d], 1);
    endtask

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{0, {11'h555, 4'd3,  1'b1}, 1'b0, 11'h000, 0, 1'b0};
        tbl[1]  = '{0, {11'h000, 4'd0,  1'b1}, 1'b0, 11'h000, 0, 1'b0};
        tbl[2]  = '{0, {11'h7FF, 4'd14, 1'b1}, 1'b0, 11'h000, 0, 1'b0};
        tbl[3]  = '{0, {11'h123, 4'd7,  1'b1}, 1'b0, 11'h000, 0, 1'b0};
        tbl[4]  = '{0, {11'h555, 4'd3,  1'b1}, 1'b0, 11'h000, 0, 1'b0};
        tbl[5]  = '{0, {11'h2AA, 4'd10, 1'b1}, 1'b0, 11'h000, 0, 1'b0};
        tbl[6]  = '{0, {11'h000, 4'd2,  1'b1}, 1'b1, 11'h001, 0, 1'b0};
        tbl[7]  = '{0, {11'h0F0, 4'd15, 1'b1}, 1'b0, 11'h000, 0, 1'b0};
        tbl[8]  = '{1, {11'h3C3, 4'd5,  1'b1}, 1'b0, 11'h000, 3, 1'b0};
        tbl[9]  = '{1, {11'h1A5, 4'd9,  1'b0}, 1'b0, 11'h000, 0, 1'b0};
        tbl[10] = '{0, {11'h6B2, 4'd4,  1'b1}, 1'b1, 11'h6B3, 0, 1'b1};

        rst_n = 1'b0;
        in_valid = '0;
        out_ready = '0;
        limpa = '0;
        force_en = '0;
        force_val = '0;
        in_dado = '0;
        reset_model();
        repeat (2) @(negedge clk);
        chk_reset(0);
        chk_reset(1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            run_vec(tbl[i].d, tbl[i].dado, tbl[i].fe, tbl[i].fv, tbl[i].hold, tbl[i].lim);
        end

        // asynchronous reset while a vector is settling in the LATENCIA=4 instance
        force_en = '0;
        in_valid[1] = 1'b1;
        in_dado[1] = {11'h7E1, 4'd6, 1'b1};
        @(negedge clk);
        in_valid[1] = 1'b0;
        chk("espera_dp_entrada", 1, dp_entrada[1], 11'h7E1);
        @(negedge clk);
        chk("espera_out_valid", 1, out_valid[1], 0);
        rst_n = 1'b0;
        #1;
        chk_reset(0);
        chk_reset(1);
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
        @(negedge clk);

        // sweep every position value, including 15
        for (int i = 0; i < 16; i++) begin
            run_vec(0, {11'($urandom), 4'(i), 1'b1}, 1'b0, 11'h000, 0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
